// File: rtl/board_mem_scheduler_if.sv
// Bus bundle between the board memory scheduler, its two requesters and the BRAM.
// master = scheduler side, slave = requester/BRAM side.
interface board_mem_scheduler_if #(
   parameter int ADDR_W = 12
) ();
   logic              ren_req_in;
   logic [ADDR_W-1:0] ren_addr_in;
   logic              ren_rvalid_out;
   logic              ren_rdata_out;

   logic              eng_req_in;
   logic              eng_we_in;
   logic [ADDR_W-1:0] eng_addr_in;
   logic              eng_wdata_in;
   logic              eng_gnt_out;
   logic              eng_rvalid_out;
   logic              eng_rdata_out;

   logic [ADDR_W-1:0] mem_addr_out;
   logic              mem_we_out;
   logic              mem_wdata_out;
   logic              mem_rdata_in;

   modport master (
      input  ren_req_in, ren_addr_in,
      output ren_rvalid_out, ren_rdata_out,
      input  eng_req_in, eng_we_in, eng_addr_in, eng_wdata_in,
      output eng_gnt_out, eng_rvalid_out, eng_rdata_out,
      output mem_addr_out, mem_we_out, mem_wdata_out,
      input  mem_rdata_in
   );

   modport slave (
      output ren_req_in, ren_addr_in,
      input  ren_rvalid_out, ren_rdata_out,
      output eng_req_in, eng_we_in, eng_addr_in, eng_wdata_in,
      input  eng_gnt_out, eng_rvalid_out, eng_rdata_out,
      input  mem_addr_out, mem_we_out, mem_wdata_out,
      output mem_rdata_in
   );
endinterface

// File: rtl/board_mem_scheduler.sv
// Shares the single-port board BRAM between the render read path (fixed priority) and the
// life engine, and launches one generation per vertical blank when running or stepped.
module board_mem_scheduler #(
   parameter int ADDR_W  = 12,
   parameter int MEM_LAT = 2,
   parameter int GEN_W   = 16
) (
   input  logic             clk_in,
   input  logic             rstn_in,
   input  logic             vsync_in,
   input  logic             run_in,
   input  logic             step_in,
   board_mem_scheduler_if.master bus,
   output logic             eng_start_out,
   input  logic             eng_done_in,
   output logic [GEN_W-1:0] gen_count_out,
   output logic             busy_out,
   output logic             overrun_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic              w_enterRun;
   logic              r_stepPending;
   logic              r_startPulse;
   logic [GEN_W-1:0]  r_genCount;
   logic              r_overrun;

   logic              w_engGnt;
   logic              w_engRead;
   logic [ADDR_W-1:0] r_memAddr;
   logic              r_memWe;
   logic              r_memWdata;
   logic [MEM_LAT:0]  r_renTag;
   logic [MEM_LAT:0]  r_engTag;

   always_comb begin
      w_nextState = r_state;
      w_enterRun  = 1'b0;
      case (r_state)
         IDLE: begin
            if (vsync_in && (run_in || r_stepPending || step_in)) begin
               w_nextState = RUN;
               w_enterRun  = 1'b1;
            end
         end
         RUN: begin
            if (eng_done_in) begin
               w_nextState = DONE;
            end
         end
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         r_state       <= IDLE;
         r_stepPending <= 1'b0;
         r_startPulse  <= 1'b0;
         r_genCount    <= '0;
         r_overrun     <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_startPulse <= w_enterRun;
         // A step arriving on the very cycle we launch is consumed by that launch.
         if (w_enterRun) begin
            r_stepPending <= 1'b0;
         end else if (step_in) begin
            r_stepPending <= 1'b1;
         end
         if (r_state == RUN && eng_done_in) begin
            r_genCount <= r_genCount + GEN_W'(1);
         end
         if (r_state == RUN && vsync_in) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign w_engGnt  = bus.eng_req_in & ~bus.ren_req_in & (r_state == RUN);
   assign w_engRead = w_engGnt & ~bus.eng_we_in;

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         r_memAddr  <= '0;
         r_memWe    <= 1'b0;
         r_memWdata <= 1'b0;
      end else if (bus.ren_req_in) begin
         r_memAddr <= bus.ren_addr_in;
         r_memWe   <= 1'b0;
      end else if (w_engGnt) begin
         r_memAddr  <= bus.eng_addr_in;
         r_memWe    <= bus.eng_we_in;
         r_memWdata <= bus.eng_wdata_in;
      end else begin
         r_memWe <= 1'b0;
      end
   end

   // Tags ride alongside the BRAM access so the returning bit lands on the port that asked.
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         r_renTag <= '0;
         r_engTag <= '0;
      end else begin
         r_renTag <= {r_renTag[MEM_LAT-1:0], bus.ren_req_in};
         r_engTag <= {r_engTag[MEM_LAT-1:0], w_engRead};
      end
   end

   assign bus.eng_gnt_out    = w_engGnt;
   assign bus.mem_addr_out   = r_memAddr;
   assign bus.mem_we_out     = r_memWe;
   assign bus.mem_wdata_out  = r_memWdata;
   assign bus.ren_rvalid_out = r_renTag[MEM_LAT];
   assign bus.ren_rdata_out  = r_renTag[MEM_LAT] & bus.mem_rdata_in;
   assign bus.eng_rvalid_out = r_engTag[MEM_LAT];
   assign bus.eng_rdata_out  = r_engTag[MEM_LAT] & bus.mem_rdata_in;

   assign eng_start_out = r_startPulse;
   assign gen_count_out = r_genCount;
   assign busy_out      = (r_state == RUN);
   assign overrun_out   = r_overrun;

endmodule
